// File: rtl/cipher_cfg_sequencer.sv
// cipher_cfg_sequencer
// Gathers a 131-bit cipher configuration as 17 bytes, shifts it LSB-first into
// the cipher scan chain while capturing the displaced old chain for readback,
// waits a short settle gap, then gates the cipher enable from run_req.
module cipher_cfg_sequencer #(
    parameter int unsigned CFG_BITS      = 131,
    parameter int unsigned NBYTES        = 17,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          byte_i,
    input  logic                byte_valid,
    output logic                byte_ready,
    input  logic                run_req,
    input  logic                abort,
    output logic                cfg_en,
    output logic                cfg_i,
    input  logic                cfg_o,
    output logic                en,
    output logic                cfg_valid,
    output logic [CFG_BITS-1:0] rb_data,
    output logic                load_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_SHIFT   = 3'd2;
    localparam logic [2:0] S_SETTLE  = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;

    localparam logic [4:0] LAST_BYTE   = 5'(NBYTES - 1);
    localparam logic [7:0] LAST_BIT    = 8'(CFG_BITS - 1);
    localparam logic [7:0] LAST_SETTLE = 8'(SETTLE_CYCLES - 1);

    logic [2:0]          state_q,      state_d;
    logic [4:0]          byte_cnt_q,   byte_cnt_d;
    logic [7:0]          bit_cnt_q,    bit_cnt_d;
    logic [7:0]          settle_cnt_q, settle_cnt_d;
    logic                cfg_en_q,     cfg_en_d;
    logic                cfg_i_q,      cfg_i_d;
    logic                en_q,         en_d;
    logic                cfg_valid_q,  cfg_valid_d;
    logic                load_done_q,  load_done_d;
    logic                abort_pend_q, abort_pend_d;
    logic [CFG_BITS-1:0] rb_shift_q,   rb_shift_d;
    logic [CFG_BITS-1:0] rb_data_q,    rb_data_d;
    logic [7:0]          cfg_buf_q [NBYTES];
    logic                wr_en;
    logic                accept;

    // Byte acceptance is purely a function of the current state
    always_comb begin
        byte_ready = (state_q == S_IDLE) || (state_q == S_COLLECT) || (state_q == S_RUN);
        accept     = byte_valid & byte_ready;
    end

    // Next-state and output-register logic for the load/shift/settle/run sequence
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        settle_cnt_d = settle_cnt_q;
        cfg_en_d     = 1'b0;
        cfg_i_d      = 1'b0;
        en_d         = 1'b0;
        cfg_valid_d  = cfg_valid_q;
        load_done_d  = 1'b0;
        abort_pend_d = abort_pend_q;
        rb_shift_d   = rb_shift_q;
        rb_data_d    = rb_data_q;
        wr_en        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wr_en      = 1'b1;
                    byte_cnt_d = 5'd1;
                    state_d    = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (abort) begin
                    byte_cnt_d = '0;
                    state_d    = S_IDLE;
                end else if (accept) begin
                    wr_en = 1'b1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        // First chain bit is driven on the same edge that stores the last byte
                        byte_cnt_d = '0;
                        bit_cnt_d  = '0;
                        cfg_en_d   = 1'b1;
                        cfg_i_d    = (byte_cnt_q == 5'd0) ? byte_i[0] : cfg_buf_q[0][0];
                        state_d    = S_SHIFT;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 5'd1;
                    end
                end
            end

            S_SHIFT: begin
                cfg_valid_d = 1'b0;
                rb_shift_d  = {cfg_o, rb_shift_q[CFG_BITS-1:1]};
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (bit_cnt_q == LAST_BIT) begin
                    rb_data_d    = rb_shift_d;
                    bit_cnt_d    = '0;
                    settle_cnt_d = '0;
                    state_d      = S_SETTLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    cfg_en_d  = 1'b1;
                    cfg_i_d   = cfg_buf_q[bit_cnt_d[7:3]][bit_cnt_d[2:0]];
                end
            end

            S_SETTLE: begin
                if (settle_cnt_q == LAST_SETTLE) begin
                    abort_pend_d = 1'b0;
                    if (abort_pend_q || abort) begin
                        cfg_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        cfg_valid_d = 1'b1;
                        load_done_d = 1'b1;
                        state_d     = S_RUN;
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                    if (abort) begin
                        abort_pend_d = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (abort) begin
                    cfg_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (accept) begin
                    wr_en       = 1'b1;
                    byte_cnt_d  = 5'd1;
                    cfg_valid_d = 1'b0;
                    state_d     = S_COLLECT;
                end else begin
                    en_d = run_req;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and readback registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            settle_cnt_q <= '0;
            cfg_en_q     <= 1'b0;
            cfg_i_q      <= 1'b0;
            en_q         <= 1'b0;
            cfg_valid_q  <= 1'b0;
            load_done_q  <= 1'b0;
            abort_pend_q <= 1'b0;
            rb_shift_q   <= '0;
            rb_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            cfg_en_q     <= cfg_en_d;
            cfg_i_q      <= cfg_i_d;
            en_q         <= en_d;
            cfg_valid_q  <= cfg_valid_d;
            load_done_q  <= load_done_d;
            abort_pend_q <= abort_pend_d;
            rb_shift_q   <= rb_shift_d;
            rb_data_q    <= rb_data_d;
        end
    end

    // Config byte buffer; pure datapath, contents only meaningful after a full collect
    always_ff @(posedge clk) begin
        if (wr_en) begin
            cfg_buf_q[byte_cnt_q] <= byte_i;
        end
    end

    assign cfg_en    = cfg_en_q;
    assign cfg_i     = cfg_i_q;
    assign en        = en_q;
    assign cfg_valid = cfg_valid_q;
    assign load_done = load_done_q;
    assign rb_data   = rb_data_q;

endmodule

// File: tb/tb_cipher_cfg_sequencer.sv
// Scoreboard bench for cipher_cfg_sequencer: an external cipher chain model
// responds to cfg_en/cfg_i; each completed shift is checked against queued
// expectations (new chain contents, readback, run length, load_done outcome).
module tb_cipher_cfg_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   byte_i;
    logic         byte_valid;
    logic         byte_ready;
    logic         run_req;
    logic         abort;
    logic         cfg_en;
    logic         cfg_i;
    logic         cfg_o;
    logic         en;
    logic         cfg_valid;
    logic [130:0] rb_data;
    logic         load_done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [130:0] new_cfg;
        logic [130:0] old_cfg;
        bit           done;
    } exp_t;
    exp_t sb[$];

    localparam logic [130:0] INIT = {3'b011, 128'h0123456789abcdef_fedcba9876543210};
    localparam logic [130:0] C2   = {3'b101, 128'h100f0e0d0c0b0a09_0807060504030201};
    localparam logic [130:0] C3   = {3'b111, 128'hffffffffffffffff_ffffffffffffffff};
    localparam logic [130:0] C5   = {3'b101, 128'ha5a5a5a5a5a5a5a5_a5a5a5a5a5a5a5a5};
    localparam logic [130:0] C6   = {3'b010, 128'h3f3e3d3c3b3a3938_3736353433323130};

    // byte k of a load sits at bits [8k+7:8k]
    localparam logic [135:0] B2 = {8'h05, 128'h100f0e0d0c0b0a09_0807060504030201};
    localparam logic [135:0] B3 = {8'hff, 128'hffffffffffffffff_ffffffffffffffff};
    localparam logic [135:0] B5 = {8'ha5, 128'ha5a5a5a5a5a5a5a5_a5a5a5a5a5a5a5a5};
    localparam logic [135:0] B6 = {8'h02, 128'h3f3e3d3c3b3a3938_3736353433323130};

    // Cipher scan chain model
    logic [130:0] chain = INIT;
    always @(posedge clk) begin
        if (cfg_en) chain <= {cfg_i, chain[130:1]};
    end
    assign cfg_o = chain[0];

    always #5 clk = ~clk;

    cipher_cfg_sequencer #(
        .CFG_BITS     (131),
        .NBYTES       (17),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .byte_i    (byte_i),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .run_req   (run_req),
        .abort     (abort),
        .cfg_en    (cfg_en),
        .cfg_i     (cfg_i),
        .cfg_o     (cfg_o),
        .en        (en),
        .cfg_valid (cfg_valid),
        .rb_data   (rb_data),
        .load_done (load_done)
    );

    task automatic check(input string name, input logic [130:0] got, input logic [130:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit ab);
        int unsigned gap = $urandom_range(0, 2);
        int t = 0;
        byte_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        byte_i = b;
        byte_valid = 1'b1;
        abort = ab;
        while (!byte_ready && t < 50) begin @(posedge clk); #1; t++; end
        if (!byte_ready) check("byte_ready_timeout", {130'd0, byte_ready}, 131'd1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
        abort = 1'b0;
    endtask

    task automatic load(input logic [135:0] bytes);
        for (int k = 0; k < 17; k++) send(bytes[8*k +: 8], 1'b0);
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        do begin @(negedge clk); t++; end while (!load_done && t < 400);
        check(name, {130'd0, load_done}, 131'd1);
    endtask

    // Monitor: consumes one scoreboard entry per completed shift
    initial begin : monitor
        int   run_len   = 0;
        bit   prev      = 1'b0;
        int   timer     = -1;
        bit   want_done = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                run_len = 0; prev = 1'b0; timer = -1;
                continue;
            end
            check("cfg_en_en_exclusive", {130'd0, cfg_en & en}, 131'd0);
            if (cfg_en) run_len++;
            if (prev && !cfg_en) begin
                if (sb.size() == 0) begin
                    check("scoreboard_empty_on_shift", 131'd1, 131'd0);
                end else begin
                    e = sb.pop_front();
                    check("shift_length", 131'(run_len), 131'd131);
                    check("cipher_chain", chain, e.new_cfg);
                    check("rb_data", rb_data, e.old_cfg);
                    check("cfg_valid_after_shift", {130'd0, cfg_valid}, 131'd0);
                    want_done = e.done;
                    timer = 0;
                end
                run_len = 0;
            end else if (timer >= 0) begin
                timer++;
                if (want_done) begin
                    if (load_done) begin
                        check("load_done_latency", 131'(timer), 131'd2);
                        check("cfg_valid_at_done", {130'd0, cfg_valid}, 131'd1);
                        timer = -1;
                    end else if (timer == 6) begin
                        check("load_done_seen", {130'd0, load_done}, 131'd1);
                        timer = -1;
                    end
                end else begin
                    check("no_load_done_after_abort", {130'd0, load_done}, 131'd0);
                    if (timer == 6) begin
                        check("cfg_valid_after_abort", {130'd0, cfg_valid}, 131'd0);
                        timer = -1;
                    end
                end
            end else if (load_done) begin
                check("unexpected_load_done", {130'd0, load_done}, 131'd0);
            end
            prev = cfg_en;
        end
    end

    logic [3:0] rr_seq;

    initial begin : stim
        rst = 1'b1; byte_i = '0; byte_valid = 1'b0; run_req = 1'b0; abort = 1'b0;
        // T1: reset values before any clock edge
        #3;
        check("rst_cfg_en", {130'd0, cfg_en}, 131'd0);
        check("rst_en", {130'd0, en}, 131'd0);
        check("rst_cfg_valid", {130'd0, cfg_valid}, 131'd0);
        check("rst_load_done", {130'd0, load_done}, 131'd0);
        check("rst_byte_ready", {130'd0, byte_ready}, 131'd1);
        check("rst_rb_data", rb_data, 131'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // T2: first load over the initial chain
        sb.push_back('{new_cfg: C2, old_cfg: INIT, done: 1'b1});
        load(B2);
        @(negedge clk);
        check("shift_cfg_en", {130'd0, cfg_en}, 131'd1);
        check("shift_byte_ready", {130'd0, byte_ready}, 131'd0);
        wait_done("t2_load_done");

        // T3: second load reads back the T2 config
        sb.push_back('{new_cfg: C3, old_cfg: C2, done: 1'b1});
        load(B3);
        wait_done("t3_load_done");
        check("t3_cfg_valid", {130'd0, cfg_valid}, 131'd1);

        // T4: RUN with one-cycle en latency, then abort
        check("run_en_initial", {130'd0, en}, 131'd0);
        rr_seq = 4'b1101; // applied LSB first: 1,0,1,1
        for (int i = 0; i < 4; i++) begin
            run_req = rr_seq[i];
            @(posedge clk); @(negedge clk);
            check("run_en_follow", {130'd0, en}, {130'd0, rr_seq[i]});
        end
        abort = 1'b1;
        @(posedge clk); @(negedge clk);
        abort = 1'b0; run_req = 1'b0;
        check("run_abort_en", {130'd0, en}, 131'd0);
        check("run_abort_cfg_valid", {130'd0, cfg_valid}, 131'd0);
        check("run_abort_idle_ready", {130'd0, byte_ready}, 131'd1);

        // T5: abort at bit 50 must not truncate the shift
        @(posedge clk); #1;
        sb.push_back('{new_cfg: C5, old_cfg: C3, done: 1'b0});
        load(B5);
        repeat (50) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        repeat (140) @(negedge clk);
        check("t5_cfg_valid", {130'd0, cfg_valid}, 131'd0);
        check("t5_idle_ready", {130'd0, byte_ready}, 131'd1);

        // T6: abort alongside the 9th byte, then a clean full load
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) send(8'hee, 1'b0);
        send(8'hee, 1'b1);
        @(negedge clk);
        check("t6_abort_ready", {130'd0, byte_ready}, 131'd1);
        check("t6_abort_cfg_en", {130'd0, cfg_en}, 131'd0);
        @(posedge clk); #1;
        sb.push_back('{new_cfg: C6, old_cfg: C5, done: 1'b1});
        load(B6);
        wait_done("t6_load_done");

        // Asynchronous reset in the middle of RUN
        run_req = 1'b1;
        @(posedge clk); @(negedge clk);
        check("pre_reset_en", {130'd0, en}, 131'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_rst_en", {130'd0, en}, 131'd0);
        check("async_rst_cfg_valid", {130'd0, cfg_valid}, 131'd0);
        check("async_rst_byte_ready", {130'd0, byte_ready}, 131'd1);
        check("async_rst_rb_data", rb_data, 131'd0);
        run_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 131'(sb.size()), 131'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
